// File: rtl/line_fill_unit.sv
// line_fill_unit: fetches a full cache line from word-wide memory after a miss,
// assembles it into a line buffer, writes it to the cache in one cycle and
// returns the missed (critical) word to the requester.
// Optional build macro: LINE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   -> fetch starts at the missed word and wraps; critical word is
//                returned right after the first beat.
//   undefined -> fetch runs from word 0; critical word is returned with the fill.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a miss (req_ready=1), no memory traffic
// FETCH  | one memory read per beat, mem_rd held high until the last ack
// DONE   | fill_valid pulse cycle, returns to IDLE on the next edge
module line_fill_unit #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_req,
  input  logic [ADDR_W-1:0]                  miss_addr,
  output logic                               req_ready,
  output logic                               mem_rd,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic                               mem_ack,
  input  logic [WORD_W-1:0]                  mem_rdata,
  output logic                               fill_valid,
  output logic [ADDR_W-1:0]                  fill_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0]   fill_data,
  output logic                               crit_valid,
  output logic [WORD_W-1:0]                  crit_data
);

  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int BOFF_W = $clog2(WORD_W / 8);
  localparam int LOFF_W = OFF_W + BOFF_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic                       accept;
  logic                       beat;
  logic                       last_beat;
  logic [ADDR_W-LOFF_W-1:0]   base_hi;
  logic [OFF_W-1:0]           idx;
  logic [OFF_W-1:0]           idx_inc;
  logic [OFF_W-1:0]           cnt;
  logic [OFF_W-1:0]           woff_in;
  logic [OFF_W-1:0]           start_idx;
  logic [LINE_W-1:0]          line_buf;
  logic [LINE_W-1:0]          line_merged;
  logic                       byte_off_unused;

  // Sub-word byte offset never matters: memory is read a whole word at a time.
  assign byte_off_unused = ^miss_addr[BOFF_W-1:0];

  assign woff_in   = miss_addr[LOFF_W-1:BOFF_W];
  assign idx_inc   = idx + OFF_W'(1);
  assign req_ready = (state == S_IDLE);

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = woff_in;
`else
  assign start_idx = '0;
  logic [OFF_W-1:0] woff_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-cycle strobes; acks outside FETCH are ignored.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    beat       = 1'b0;
    last_beat  = 1'b0;
    unique case (state)
      S_IDLE: begin
        accept = miss_req;
        if (miss_req) state_next = S_FETCH;
      end
      S_FETCH: begin
        beat = mem_ack;
        if (mem_ack && (&cnt)) begin
          last_beat  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Line buffer with the current beat merged in, so the final word lands in
  // fill_data on the same edge as the last ack.
  always_comb begin
    line_merged = line_buf;
    line_merged[int'(idx)*WORD_W +: WORD_W] = mem_rdata;
  end

  // Datapath: beat tracking, memory request, line assembly and output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_hi    <= '0;
      idx        <= '0;
      cnt        <= '0;
      line_buf   <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
`ifndef LINE_FILL_CRITICAL_WORD_FIRST_EN
      woff_q     <= '0;
`endif
    end else begin
      fill_valid <= 1'b0;
      crit_valid <= 1'b0;

      if (accept) begin
        base_hi  <= miss_addr[ADDR_W-1:LOFF_W];
        idx      <= start_idx;
        cnt      <= '0;
        mem_rd   <= 1'b1;
        mem_addr <= {miss_addr[ADDR_W-1:LOFF_W], start_idx, {BOFF_W{1'b0}}};
`ifndef LINE_FILL_CRITICAL_WORD_FIRST_EN
        woff_q   <= woff_in;
`endif
      end

      if (beat) begin
        line_buf[int'(idx)*WORD_W +: WORD_W] <= mem_rdata;
        idx <= idx_inc;
        cnt <= cnt + OFF_W'(1);
        if (last_beat) begin
          mem_rd     <= 1'b0;
          fill_valid <= 1'b1;
          fill_addr  <= {base_hi, {LOFF_W{1'b0}}};
          fill_data  <= line_merged;
`ifndef LINE_FILL_CRITICAL_WORD_FIRST_EN
          crit_valid <= 1'b1;
          crit_data  <= line_merged[int'(woff_q)*WORD_W +: WORD_W];
`endif
        end else begin
          mem_addr <= {base_hi, idx_inc, {BOFF_W{1'b0}}};
        end
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
        if (cnt == '0) begin
          crit_valid <= 1'b1;
          crit_data  <= mem_rdata;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// Directed bench for line_fill_unit. Memory model returns the word address as
// data, so every expected word is derivable from its address.
module tb_line_fill_unit;

  logic         clk;
  logic         rst_n;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         req_ready;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [511:0] fill_data;
  logic         crit_valid;
  logic [31:0]  crit_data;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  line_fill_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .req_ready  (req_ready),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .crit_valid (crit_valid),
    .crit_data  (crit_data)
  );

  // Memory returns data equal to the requested address.
  assign mem_rdata = mem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] line_of(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i * 4);
    return l;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; mem_ack = 1'b0;
    tick(); tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset mem_rd: got %b expected 0", mem_rd); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL reset fill_valid: got %b expected 0", fill_valid); end
    n_checks++; if (fill_addr !== 32'h0) begin n_fail++; $display("FAIL reset fill_addr: got %h expected 0", fill_addr); end
    n_checks++; if (fill_data !== 512'h0) begin n_fail++; $display("FAIL reset fill_data: got %h expected 0", fill_data); end
    n_checks++; if (crit_valid !== 1'b0) begin n_fail++; $display("FAIL reset crit_valid: got %b expected 0", crit_valid); end
    n_checks++; if (crit_data !== 32'h0) begin n_fail++; $display("FAIL reset crit_data: got %h expected 0", crit_data); end
    rst_n = 1'b1;
    tick();
  endtask

  // One full miss with mem_ack tied high; sample c is taken after edge E<c>.
  task automatic run_fill(input logic [31:0] addr, input string name);
    logic [31:0]  base;
    logic [511:0] exp_line;
    logic [31:0]  exp_addr;
    int           woff, start, crit_c;
    base     = addr & 32'hFFFF_FFC0;
    woff     = int'((addr >> 2) & 32'hF);
    start    = CWF ? woff : 0;
    crit_c   = CWF ? 1 : 16;
    exp_line = line_of(base);
    miss_addr = addr; miss_req = 1'b1; mem_ack = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      tick();
      if (c == 0) miss_req = 1'b0;
      if (c <= 15) begin
        exp_addr = base + 32'(((start + c) % 16) * 4);
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== exp_addr) begin
          n_fail++; $display("FAIL %s mem_addr beat %0d: got rd=%b %h expected rd=1 %h", name, c, mem_rd, mem_addr, exp_addr); end
      end
      n_checks++; if (req_ready !== (c == 17)) begin
        n_fail++; $display("FAIL %s req_ready cycle %0d: got %b expected %b", name, c, req_ready, c == 17); end
      n_checks++; if (fill_valid !== (c == 16)) begin
        n_fail++; $display("FAIL %s fill_valid cycle %0d: got %b expected %b", name, c, fill_valid, c == 16); end
      n_checks++; if (crit_valid !== (c == crit_c)) begin
        n_fail++; $display("FAIL %s crit_valid cycle %0d: got %b expected %b", name, c, crit_valid, c == crit_c); end
      if (c == crit_c) begin
        n_checks++; if (crit_data !== base + 32'(woff * 4)) begin
          n_fail++; $display("FAIL %s crit_data: got %h expected %h", name, crit_data, base + 32'(woff * 4)); end
      end
      if (c == 16) begin
        n_checks++; if (fill_addr !== base) begin
          n_fail++; $display("FAIL %s fill_addr: got %h expected %h", name, fill_addr, base); end
        n_checks++; if (mem_rd !== 1'b0) begin
          n_fail++; $display("FAIL %s mem_rd after last beat: got %b expected 0", name, mem_rd); end
      end
      if (c >= 16) begin
        n_checks++; if (fill_data !== exp_line) begin
          n_fail++; $display("FAIL %s fill_data cycle %0d: got %h expected %h", name, c, fill_data, exp_line); end
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_sequential();
    run_fill(32'h0000_1048, "sequential");
  endtask

  task automatic test_critical_first();
    run_fill(32'h0000_107C, "critical_first");
  endtask

  task automatic test_back_to_back();
    run_fill(32'h0000_8000, "b2b_first");
    run_fill(32'hABCD_0F34, "b2b_second");
  endtask

  task automatic test_stalls_extra_req();
    logic [31:0]  exp_addr;
    logic [511:0] exp_line;
    exp_line = line_of(32'h0000_2000);
    miss_addr = 32'h0000_2000; miss_req = 1'b1; mem_ack = 1'b0;
    tick();
    miss_req = 1'b0;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_2000) begin
      n_fail++; $display("FAIL stall first mem_addr: got rd=%b %h expected rd=1 00002000", mem_rd, mem_addr); end
    for (int j = 1; j <= 49; j++) begin
      mem_ack  = (j % 3 == 0) && (j <= 48);
      miss_req = (j >= 10) && (j <= 12);
      if (miss_req) miss_addr = 32'h0000_3000;
      tick();
      if (j < 48) begin
        exp_addr = 32'h0000_2000 + 32'((j / 3) * 4);
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== exp_addr) begin
          n_fail++; $display("FAIL stall mem_addr cycle %0d: got rd=%b %h expected rd=1 %h", j, mem_rd, mem_addr, exp_addr); end
        n_checks++; if (req_ready !== 1'b0 || fill_valid !== 1'b0) begin
          n_fail++; $display("FAIL stall busy cycle %0d: got ready=%b fill=%b expected ready=0 fill=0", j, req_ready, fill_valid); end
      end else if (j == 48) begin
        n_checks++; if (fill_valid !== 1'b1 || fill_addr !== 32'h0000_2000) begin
          n_fail++; $display("FAIL stall fill: got valid=%b addr=%h expected valid=1 addr=00002000", fill_valid, fill_addr); end
        n_checks++; if (fill_data !== exp_line) begin
          n_fail++; $display("FAIL stall fill_data: got %h expected %h", fill_data, exp_line); end
      end else begin
        n_checks++; if (req_ready !== 1'b1 || mem_rd !== 1'b0 || fill_valid !== 1'b0) begin
          n_fail++; $display("FAIL stall second request: got ready=%b rd=%b fill=%b expected 1 0 0", req_ready, mem_rd, fill_valid); end
      end
    end
    mem_ack = 1'b0; miss_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    logic bad;
    miss_addr = 32'h0000_4010; miss_req = 1'b1; mem_ack = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      if (c == 0) miss_req = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    n_checks++; if (mem_rd !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL midreset state: got rd=%b ready=%b addr=%h expected 0 1 0", mem_rd, req_ready, mem_addr); end
    n_checks++; if (fill_valid !== 1'b0 || crit_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset pulses: got fill=%b crit=%b expected 0 0", fill_valid, crit_valid); end
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_rd !== 1'b0 || fill_valid !== 1'b0 || crit_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin
      n_fail++; $display("FAIL midreset quiet: got activity=%b expected 0", bad); end
    mem_ack = 1'b0;
    run_fill(32'h0000_5004, "post_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_critical_first();
    test_back_to_back();
    test_stalls_extra_req();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
